// File: rtl/main_ctrl_pkg.sv
// Shared encodings for the multicycle main controller and the ALU control block:
// opcodes, datapath select codes, FSM state encodings and the control word layout.
package main_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/main_ctrl_fsm.sv
// Multicycle main control FSM: one state register, next-state decode and output
// decode as separate combinational blocks. Outputs forced low while rst_n is low.
module main_ctrl_fsm
  import main_ctrl_pkg::*;
#(
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_o;
  logic   op_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: op_legal = 1'b1;
      OP_ADDI:                              op_legal = ENABLE_ADDI;
      default:                              op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = ENABLE_ADDI ? S_ADDIEX : S_FETCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // FETCH's ir_write/pc_write follow mem_ready so the IR and PC load only on completion.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRC_B_IMM_SH2;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.illegal_op = !op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEMRD: ctrl.i_or_d = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNC;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = PC_SRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign ctrl_o     = rst_n ? ctrl : '0;
  assign pc_write   = ctrl_o.pc_write;
  assign branch     = ctrl_o.branch;
  assign i_or_d     = ctrl_o.i_or_d;
  assign mem_write  = ctrl_o.mem_write;
  assign ir_write   = ctrl_o.ir_write;
  assign mem_to_reg = ctrl_o.mem_to_reg;
  assign reg_write  = ctrl_o.reg_write;
  assign reg_dst    = ctrl_o.reg_dst;
  assign alu_src_a  = ctrl_o.alu_src_a;
  assign alu_src_b  = ctrl_o.alu_src_b;
  assign alu_op     = ctrl_o.alu_op;
  assign pc_src     = ctrl_o.pc_src;
  assign illegal_op = ctrl_o.illegal_op;
  assign state      = state_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm: dut_a with ADDI enabled, dut_b with ADDI disabled,
// both sharing clock, reset and inputs.
module tb_main_ctrl_fsm;
  import main_ctrl_pkg::*;

  // Output word layout: {pc_write,branch,i_or_d,mem_write,ir_write,mem_to_reg,
  //                      reg_write,reg_dst,alu_src_a,alu_src_b[2],alu_op[2],pc_src[2],illegal_op}
  localparam logic [15:0] O_ZERO    = 16'b0000_0000_0000_0000;
  localparam logic [15:0] O_FETCH   = 16'b1000_1000_0010_0000;
  localparam logic [15:0] O_FETCH_W = 16'b0000_0000_0010_0000;
  localparam logic [15:0] O_DECODE  = 16'b0000_0000_0110_0000;
  localparam logic [15:0] O_DEC_ILL = 16'b0000_0000_0110_0001;
  localparam logic [15:0] O_MEMADR  = 16'b0000_0000_1100_0000;
  localparam logic [15:0] O_MEMRD   = 16'b0010_0000_0000_0000;
  localparam logic [15:0] O_MEMWB   = 16'b0000_0110_0000_0000;
  localparam logic [15:0] O_MEMWR   = 16'b0011_0000_0000_0000;
  localparam logic [15:0] O_EXECUTE = 16'b0000_0000_1001_0000;
  localparam logic [15:0] O_ALUWB   = 16'b0000_0011_0000_0000;
  localparam logic [15:0] O_BRANCH  = 16'b0100_0000_1000_1010;
  localparam logic [15:0] O_ADDIEX  = 16'b0000_0000_1100_0000;
  localparam logic [15:0] O_ADDIWB  = 16'b0000_0010_0000_0000;
  localparam logic [15:0] O_JUMP    = 16'b1000_0000_0000_0100;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;

  logic       pc_write_a, branch_a, i_or_d_a, mem_write_a, ir_write_a, mem_to_reg_a;
  logic       reg_write_a, reg_dst_a, alu_src_a_a, illegal_op_a;
  logic [1:0] alu_src_b_a, alu_op_a, pc_src_a;
  logic [3:0] state_a;
  logic       pc_write_b, branch_b, i_or_d_b, mem_write_b, ir_write_b, mem_to_reg_b;
  logic       reg_write_b, reg_dst_b, alu_src_a_b, illegal_op_b;
  logic [1:0] alu_src_b_b, alu_op_b, pc_src_b;
  logic [3:0] state_b;
  logic [15:0] obs_a, obs_b;

  int errors = 0;
  int checks = 0;

  main_ctrl_fsm #(.ENABLE_ADDI(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write_a), .branch(branch_a), .i_or_d(i_or_d_a), .mem_write(mem_write_a),
    .ir_write(ir_write_a), .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a),
    .reg_dst(reg_dst_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
    .alu_op(alu_op_a), .pc_src(pc_src_a), .illegal_op(illegal_op_a), .state(state_a)
  );

  main_ctrl_fsm #(.ENABLE_ADDI(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .branch(branch_b), .i_or_d(i_or_d_b), .mem_write(mem_write_b),
    .ir_write(ir_write_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
    .reg_dst(reg_dst_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
    .alu_op(alu_op_b), .pc_src(pc_src_b), .illegal_op(illegal_op_b), .state(state_b)
  );

  assign obs_a = {pc_write_a, branch_a, i_or_d_a, mem_write_a, ir_write_a, mem_to_reg_a,
                  reg_write_a, reg_dst_a, alu_src_a_a, alu_src_b_a, alu_op_a, pc_src_a, illegal_op_a};
  assign obs_b = {pc_write_b, branch_b, i_or_d_b, mem_write_b, ir_write_b, mem_to_reg_b,
                  reg_write_b, reg_dst_b, alu_src_a_b, alu_src_b_b, alu_op_b, pc_src_b, illegal_op_b};

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = OP_RTYPE;
    #3;
    checks += 3;
    if (state_a !== S_FETCH) begin errors++; $display("FAIL reset state_a: got %0d expected %0d", state_a, S_FETCH); end
    if (obs_a !== O_ZERO) begin errors++; $display("FAIL reset outs_a: got %b expected %b", obs_a, O_ZERO); end
    if (obs_b !== O_ZERO) begin errors++; $display("FAIL reset outs_b: got %b expected %b", obs_b, O_ZERO); end
    tick();
    checks += 2;
    if (state_a !== S_FETCH) begin errors++; $display("FAIL reset hold state_a: got %0d expected %0d", state_a, S_FETCH); end
    if (obs_a !== O_ZERO) begin errors++; $display("FAIL reset hold outs_a: got %b expected %b", obs_a, O_ZERO); end
    rst_n = 1'b1;
    #1;
    checks += 2;
    if (state_a !== S_FETCH) begin errors++; $display("FAIL reset release state_a: got %0d expected %0d", state_a, S_FETCH); end
    if (obs_a !== O_FETCH) begin errors++; $display("FAIL reset release outs_a: got %b expected %b", obs_a, O_FETCH); end
  endtask

  // lw with mem_ready=1; op is scrambled after MEMADR and must be ignored.
  task automatic test_lw();
    logic [3:0]  es [6];
    logic [15:0] eo [6];
    es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
    eo = '{O_FETCH, O_DECODE, O_MEMADR, O_MEMRD, O_MEMWB, O_FETCH};
    for (int i = 0; i < 6; i++) begin
      op = (i < 3) ? OP_LW : 6'b111111;
      mem_ready = 1'b1;
      #1;
      checks += 4;
      if (state_a !== es[i]) begin errors++; $display("FAIL lw state_a cyc%0d: got %0d expected %0d", i, state_a, es[i]); end
      if (obs_a !== eo[i]) begin errors++; $display("FAIL lw outs_a cyc%0d: got %b expected %b", i, obs_a, eo[i]); end
      if (state_b !== es[i]) begin errors++; $display("FAIL lw state_b cyc%0d: got %0d expected %0d", i, state_b, es[i]); end
      if (obs_b !== eo[i]) begin errors++; $display("FAIL lw outs_b cyc%0d: got %b expected %b", i, obs_b, eo[i]); end
      if (i < 5) tick();
    end
  endtask

  // sw with three wait cycles in MEMWR: mem_write held four cycles, seven total.
  task automatic test_sw_stall();
    logic [3:0]  es [8];
    logic [15:0] eo [8];
    logic        mr [8];
    es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_MEMWR, S_MEMWR, S_FETCH};
    eo = '{O_FETCH, O_DECODE, O_MEMADR, O_MEMWR, O_MEMWR, O_MEMWR, O_MEMWR, O_FETCH};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      op = OP_SW;
      mem_ready = mr[i];
      #1;
      checks += 2;
      if (state_a !== es[i]) begin errors++; $display("FAIL sw state_a cyc%0d: got %0d expected %0d", i, state_a, es[i]); end
      if (obs_a !== eo[i]) begin errors++; $display("FAIL sw outs_a cyc%0d: got %b expected %b", i, obs_a, eo[i]); end
      if (i < 7) tick();
    end
  endtask

  // R-type preceded by two FETCH wait cycles.
  task automatic test_rtype_fetch_stall();
    logic [3:0]  es [7];
    logic [15:0] eo [7];
    logic        mr [7];
    es = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB, S_FETCH};
    eo = '{O_FETCH_W, O_FETCH_W, O_FETCH, O_DECODE, O_EXECUTE, O_ALUWB, O_FETCH};
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      op = OP_RTYPE;
      mem_ready = mr[i];
      #1;
      checks += 2;
      if (state_a !== es[i]) begin errors++; $display("FAIL rtype state_a cyc%0d: got %0d expected %0d", i, state_a, es[i]); end
      if (obs_a !== eo[i]) begin errors++; $display("FAIL rtype outs_a cyc%0d: got %b expected %b", i, obs_a, eo[i]); end
      if (i < 6) tick();
    end
  endtask

  task automatic test_branch_jump();
    logic [3:0]  es [7];
    logic [15:0] eo [7];
    es = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_JUMP, S_FETCH};
    eo = '{O_FETCH, O_DECODE, O_BRANCH, O_FETCH, O_DECODE, O_JUMP, O_FETCH};
    for (int i = 0; i < 7; i++) begin
      op = (i < 3) ? OP_BEQ : OP_J;
      mem_ready = 1'b1;
      #1;
      checks += 2;
      if (state_a !== es[i]) begin errors++; $display("FAIL brj state_a cyc%0d: got %0d expected %0d", i, state_a, es[i]); end
      if (obs_a !== eo[i]) begin errors++; $display("FAIL brj outs_a cyc%0d: got %b expected %b", i, obs_a, eo[i]); end
      if (i < 6) tick();
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  es [3];
    logic [15:0] eo [3];
    es = '{S_FETCH, S_DECODE, S_FETCH};
    eo = '{O_FETCH, O_DEC_ILL, O_FETCH};
    for (int i = 0; i < 3; i++) begin
      op = 6'b111111;
      mem_ready = 1'b1;
      #1;
      checks += 4;
      if (state_a !== es[i]) begin errors++; $display("FAIL ill state_a cyc%0d: got %0d expected %0d", i, state_a, es[i]); end
      if (obs_a !== eo[i]) begin errors++; $display("FAIL ill outs_a cyc%0d: got %b expected %b", i, obs_a, eo[i]); end
      if (state_b !== es[i]) begin errors++; $display("FAIL ill state_b cyc%0d: got %0d expected %0d", i, state_b, es[i]); end
      if (obs_b !== eo[i]) begin errors++; $display("FAIL ill outs_b cyc%0d: got %b expected %b", i, obs_b, eo[i]); end
      if (i < 2) tick();
    end
  endtask

  // addi: legal on dut_a, illegal (2-cycle loop back to FETCH) on dut_b.
  task automatic test_addi();
    logic [3:0]  esa [5];
    logic [15:0] eoa [5];
    logic [3:0]  esb [5];
    logic [15:0] eob [5];
    esa = '{S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH};
    eoa = '{O_FETCH, O_DECODE, O_ADDIEX, O_ADDIWB, O_FETCH};
    esb = '{S_FETCH, S_DECODE, S_FETCH, S_DECODE, S_FETCH};
    eob = '{O_FETCH, O_DEC_ILL, O_FETCH, O_DEC_ILL, O_FETCH};
    for (int i = 0; i < 5; i++) begin
      op = OP_ADDI;
      mem_ready = 1'b1;
      #1;
      checks += 4;
      if (state_a !== esa[i]) begin errors++; $display("FAIL addi state_a cyc%0d: got %0d expected %0d", i, state_a, esa[i]); end
      if (obs_a !== eoa[i]) begin errors++; $display("FAIL addi outs_a cyc%0d: got %b expected %b", i, obs_a, eoa[i]); end
      if (state_b !== esb[i]) begin errors++; $display("FAIL addi state_b cyc%0d: got %0d expected %0d", i, state_b, esb[i]); end
      if (obs_b !== eob[i]) begin errors++; $display("FAIL addi outs_b cyc%0d: got %b expected %b", i, obs_b, eob[i]); end
      if (i < 4) tick();
    end
  endtask

  // Reset asserted in the middle of a stalled MEMWR, then an R-type afterwards.
  task automatic test_reset_mid_write();
    logic [3:0] es [4];
    es = '{S_DECODE, S_EXECUTE, S_ALUWB, S_FETCH};
    rst_n = 1'b0; #1; rst_n = 1'b1;
    op = OP_SW; mem_ready = 1'b1;
    #1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    checks += 2;
    if (state_a !== S_MEMWR) begin errors++; $display("FAIL rstwr pre state: got %0d expected %0d", state_a, S_MEMWR); end
    if (mem_write_a !== 1'b1) begin errors++; $display("FAIL rstwr pre mem_write: got %b expected 1", mem_write_a); end
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (state_a !== S_FETCH) begin errors++; $display("FAIL rstwr async state: got %0d expected %0d", state_a, S_FETCH); end
    if (mem_write_a !== 1'b0) begin errors++; $display("FAIL rstwr async mem_write: got %b expected 0", mem_write_a); end
    if (obs_a !== O_ZERO) begin errors++; $display("FAIL rstwr async outs: got %b expected %b", obs_a, O_ZERO); end
    tick();
    checks += 2;
    if (state_a !== S_FETCH) begin errors++; $display("FAIL rstwr held state: got %0d expected %0d", state_a, S_FETCH); end
    if (obs_a !== O_ZERO) begin errors++; $display("FAIL rstwr held outs: got %b expected %b", obs_a, O_ZERO); end
    rst_n = 1'b1;
    op = OP_RTYPE;
    #1;
    checks += 1;
    if (obs_a !== O_FETCH) begin errors++; $display("FAIL rstwr release outs: got %b expected %b", obs_a, O_FETCH); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 2;
      if (state_a !== es[i]) begin errors++; $display("FAIL rstwr after state cyc%0d: got %0d expected %0d", i, state_a, es[i]); end
      if (mem_write_a !== 1'b0) begin errors++; $display("FAIL rstwr after mem_write cyc%0d: got %b expected 0", i, mem_write_a); end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype_fetch_stall();
    test_branch_jump();
    test_illegal();
    test_addi();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
